// File: rtl/prescaled_updown_counter.sv
// Multi-digit up/down counter advanced by an internal two-rate prescaler.
// Supports synchronous clear and load, and gives registered tick/carry/borrow pulses.
// Every register runs on clk; there is no derived clock.
module prescaled_updown_counter #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned RADIX         = 10,
  parameter int unsigned PRESCALE_FAST = 9000,
  parameter int unsigned PRESCALE_SLOW = 48000000,
  parameter int unsigned PW            =
      $clog2(((PRESCALE_FAST > PRESCALE_SLOW) ? PRESCALE_FAST : PRESCALE_SLOW) + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  clr,
  input  logic                  up,
  input  logic                  slow,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   di,
  output logic [4*DIGITS-1:0]   data,
  output logic                  tick,
  output logic                  carry,
  output logic                  borrow
);

  localparam logic [PW-1:0] FastM1 = PW'(PRESCALE_FAST - 1);
  localparam logic [PW-1:0] SlowM1 = PW'(PRESCALE_SLOW - 1);
  localparam logic [3:0]    DigMax = 4'(RADIX - 1);

  logic [PW-1:0]       p_q, p_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic                tick_q, tick_d;
  logic                carry_q, carry_d;
  logic                borrow_q, borrow_d;

  logic [PW-1:0]       limit_m1;
  logic                step;
  logic [4*DIGITS-1:0] cnt_up, cnt_dn, di_sat;
  logic                wrap_up, wrap_dn;

  // Prescaler: >= rather than == so a switch to a shorter period never overruns.
  always_comb begin
    limit_m1 = slow ? SlowM1 : FastM1;
    step     = (p_q >= limit_m1);
    p_d      = step ? '0 : p_q + PW'(1);
  end

  // Ripple increment/decrement across all digits, plus load-value saturation.
  always_comb begin
    logic [3:0] dig;
    logic       cy;
    logic       bw;
    cnt_up = data_q;
    cnt_dn = data_q;
    di_sat = di;
    cy     = 1'b1;
    bw     = 1'b1;
    dig    = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = data_q[4*i +: 4];
      if (cy) begin
        if (dig == DigMax) begin
          cnt_up[4*i +: 4] = 4'd0;
        end else begin
          cnt_up[4*i +: 4] = dig + 4'd1;
          cy               = 1'b0;
        end
      end
      if (bw) begin
        if (dig == 4'd0) begin
          cnt_dn[4*i +: 4] = DigMax;
        end else begin
          cnt_dn[4*i +: 4] = dig - 4'd1;
          bw               = 1'b0;
        end
      end
      if (di[4*i +: 4] > DigMax) di_sat[4*i +: 4] = DigMax;
    end
    // Carry/borrow survive the whole chain only when every digit wrapped.
    wrap_up = cy;
    wrap_dn = bw;
  end

  // Counter next state: clr > load > counted step > hold; wrap pulses only on a real count.
  always_comb begin
    data_d   = data_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    tick_d   = step;
    if (clr) begin
      data_d = '0;
    end else if (load) begin
      data_d = di_sat;
    end else if (step && ce) begin
      if (up) begin
        data_d  = cnt_up;
        carry_d = wrap_up;
      end else begin
        data_d   = cnt_dn;
        borrow_d = wrap_dn;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q      <= '0;
      data_q   <= '0;
      tick_q   <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      p_q      <= p_d;
      data_q   <= data_d;
      tick_q   <= tick_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign data   = data_q;
  assign tick   = tick_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench: a BCD 2-digit instance (fast=4, slow=10) and a hex 4-digit instance.
module tb_prescaled_updown_counter;

  logic       clk;
  logic       rst, ce, clr, up, slow, load;
  logic [7:0] di, data;
  logic       tick, carry, borrow;

  logic        rst6, load6;
  logic [15:0] di6, data6;
  logic        tick6, carry6, borrow6;

  int checks   = 0;
  int failures = 0;

  prescaled_updown_counter #(
    .DIGITS(2), .RADIX(10), .PRESCALE_FAST(4), .PRESCALE_SLOW(10)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .clr(clr), .up(up), .slow(slow), .load(load),
    .di(di), .data(data), .tick(tick), .carry(carry), .borrow(borrow)
  );

  prescaled_updown_counter #(
    .DIGITS(4), .RADIX(16), .PRESCALE_FAST(4), .PRESCALE_SLOW(10)
  ) dut6 (
    .clk(clk), .rst(rst6), .ce(1'b1), .clr(1'b0), .up(1'b1), .slow(1'b0), .load(load6),
    .di(di6), .data(data6), .tick(tick6), .carry(carry6), .borrow(borrow6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect tick low for n-1 edges and high right after the n-th edge.
  task automatic expect_step(input int n, input string name);
    logic exp;
    for (int i = 1; i <= n; i++) begin
      cyc(1);
      exp = (i == n);
      checks++;
      if (tick !== exp) begin
        failures++;
        $display("FAIL %s edge %0d: tick=%b required %b", name, i, tick, exp);
      end
    end
  endtask

  task automatic expect_step6(input int n, input string name);
    logic exp;
    for (int i = 1; i <= n; i++) begin
      cyc(1);
      exp = (i == n);
      checks++;
      if (tick6 !== exp) begin
        failures++;
        $display("FAIL %s edge %0d: tick=%b required %b", name, i, tick6, exp);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ce = 1'b1; clr = 1'b0; up = 1'b1; slow = 1'b0; load = 1'b0; di = 8'h00;
    cyc(2);
    checks++;
    if ({data, tick, carry, borrow} !== 11'h0) begin
      failures++;
      $display("FAIL reset: data=%h tick=%b carry=%b borrow=%b required all 0",
               data, tick, carry, borrow);
    end
    rst = 1'b0;
  endtask

  // First step on the 4th edge after release, then every 4 edges.
  task automatic test_count_up;
    for (int k = 1; k <= 3; k++) begin
      for (int e = 1; e <= 4; e++) begin
        cyc(1);
        checks++;
        if (e < 4) begin
          if (data !== 8'(k - 1) || tick !== 1'b0) begin
            failures++;
            $display("FAIL count_up k=%0d e=%0d: data=%h tick=%b required %h 0",
                     k, e, data, tick, 8'(k - 1));
          end
        end else begin
          if (data !== 8'(k) || tick !== 1'b1) begin
            failures++;
            $display("FAIL count_up k=%0d step: data=%h tick=%b required %h 1",
                     k, data, tick, 8'(k));
          end
        end
      end
    end
  endtask

  task automatic test_up_wrap;
    load = 1'b1; di = 8'h99;
    cyc(1);
    load = 1'b0;
    checks++;
    if (data !== 8'h99) begin
      failures++; $display("FAIL load_99: data=%h required 99", data);
    end
    expect_step(3, "up_wrap_step");
    checks++;
    if (data !== 8'h00 || carry !== 1'b1 || borrow !== 1'b0) begin
      failures++;
      $display("FAIL up_wrap: data=%h carry=%b borrow=%b required 00 1 0", data, carry, borrow);
    end
    cyc(1);
    checks++;
    if (carry !== 1'b0) begin
      failures++; $display("FAIL carry_one_cycle: carry=%b required 0", carry);
    end
    load = 1'b1; di = 8'h09;
    cyc(1);
    load = 1'b0;
    expect_step(2, "digit_carry_step");
    checks++;
    if (data !== 8'h10 || carry !== 1'b0) begin
      failures++; $display("FAIL digit_carry: data=%h carry=%b required 10 0", data, carry);
    end
  endtask

  task automatic test_down_wrap;
    up = 1'b0; load = 1'b1; di = 8'h00;
    cyc(1);
    load = 1'b0;
    expect_step(3, "down_wrap_step");
    checks++;
    if (data !== 8'h99 || borrow !== 1'b1 || carry !== 1'b0) begin
      failures++;
      $display("FAIL down_wrap: data=%h borrow=%b carry=%b required 99 1 0", data, borrow, carry);
    end
    cyc(1);
    checks++;
    if (borrow !== 1'b0) begin
      failures++; $display("FAIL borrow_one_cycle: borrow=%b required 0", borrow);
    end
    load = 1'b1; di = 8'h10;
    cyc(1);
    load = 1'b0;
    expect_step(2, "digit_borrow_step");
    checks++;
    if (data !== 8'h09 || borrow !== 1'b0) begin
      failures++; $display("FAIL digit_borrow: data=%h borrow=%b required 09 0", data, borrow);
    end
  endtask

  task automatic test_illegal_load;
    up = 1'b1; load = 1'b1; di = 8'hFA;
    cyc(1);
    load = 1'b0;
    checks++;
    if (data !== 8'h99) begin
      failures++; $display("FAIL sat_load: data=%h required 99", data);
    end
    cyc(2);
    // Next edge is a step; clr+load win, the step is lost and no carry from 99.
    clr = 1'b1; load = 1'b1; di = 8'h99;
    cyc(1);
    clr = 1'b0; load = 1'b0;
    checks++;
    if (data !== 8'h00 || carry !== 1'b0 || tick !== 1'b1) begin
      failures++;
      $display("FAIL clr_load_step: data=%h carry=%b tick=%b required 00 0 1", data, carry, tick);
    end
  endtask

  task automatic test_prescale_switch;
    cyc(2);
    slow = 1'b1;
    // p=2 with limit 10: step lands on edge 10-2.
    expect_step(8, "slow_first_step");
    checks++;
    if (data !== 8'h01) begin
      failures++; $display("FAIL slow_first_data: data=%h required 01", data);
    end
    expect_step(10, "slow_period");
    checks++;
    if (data !== 8'h02) begin
      failures++; $display("FAIL slow_period_data: data=%h required 02", data);
    end
    cyc(8);
    slow = 1'b0;
    expect_step(1, "fast_switch_step");
    checks++;
    if (data !== 8'h03) begin
      failures++; $display("FAIL fast_switch_data: data=%h required 03", data);
    end
    ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      expect_step(4, "hold_tick");
      checks++;
      if (data !== 8'h03) begin
        failures++; $display("FAIL hold_data: data=%h required 03", data);
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_hex;
    cyc(1);
    checks++;
    if ({data6, tick6, carry6, borrow6} !== 19'h0) begin
      failures++;
      $display("FAIL hex_reset: data=%h tick=%b carry=%b required all 0", data6, tick6, carry6);
    end
    rst6 = 1'b0; load6 = 1'b1; di6 = 16'hFFFF;
    cyc(1);
    load6 = 1'b0;
    checks++;
    if (data6 !== 16'hFFFF) begin
      failures++; $display("FAIL hex_load: data=%h required ffff", data6);
    end
    expect_step6(3, "hex_wrap_step");
    checks++;
    if (data6 !== 16'h0000 || carry6 !== 1'b1 || borrow6 !== 1'b0) begin
      failures++;
      $display("FAIL hex_wrap: data=%h carry=%b borrow=%b required 0000 1 0",
               data6, carry6, borrow6);
    end
    load6 = 1'b1; di6 = 16'hFFFF;
    cyc(1);
    load6 = 1'b0;
    cyc(2);
    // This edge would be a wrapping step; reset must cancel it entirely.
    rst6 = 1'b1;
    cyc(1);
    checks++;
    if ({data6, tick6, carry6, borrow6} !== 19'h0) begin
      failures++;
      $display("FAIL hex_mid_reset: data=%h tick=%b carry=%b required all 0",
               data6, tick6, carry6);
    end
    rst6 = 1'b0;
    expect_step6(4, "hex_after_reset");
    checks++;
    if (data6 !== 16'h0001 || carry6 !== 1'b0) begin
      failures++; $display("FAIL hex_after_reset_data: data=%h carry=%b required 0001 0",
                           data6, carry6);
    end
  endtask

  initial begin
    rst6 = 1'b1; load6 = 1'b0; di6 = 16'h0;
    test_reset();
    test_count_up();
    test_up_wrap();
    test_down_wrap();
    test_illegal_load();
    test_prescale_switch();
    test_hex();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
